tsp_city_loader: RTL and testbench

TSP_CITY_LOADER -- requirements
Module: tsp_city_loader

---
 rtl/tsp_city_loader_if.sv | 17 +
 rtl/tsp_city_loader.sv | 152 +++++++++++++++
 tb/tb_tsp_city_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsp_city_loader_if.sv
// ---------------------------------------------------------------------------
// tsp_city_loader_if
// Byte-stream valid/ready handshake feeding the city loader.
//   in_valid : source has a byte on in_data
//   in_data  : 8-bit stream byte
//   in_ready : loader accepts in_data this cycle
// A byte transfers on a clock edge where in_valid and in_ready are both high.
// Modports: master = byte source, slave = loader.
// ---------------------------------------------------------------------------
interface tsp_city_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/tsp_city_loader.sv
// ---------------------------------------------------------------------------
// tsp_city_loader
// Parses a framed byte stream of city coordinates into two 64-entry arrays.
// Frame: HEADER, N, (x_0,y_0) .. (x_N-1,y_N-1), C  with C = XOR of N and
// every coordinate byte. A verified frame raises coords_valid and pulses
// load_done; a bad count or bad checksum pulses load_err.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous, active-low reset
//   bus          : byte-stream handshake (slave side)
//   xs, ys       : city coordinates, index 0..63
//   city_count   : cities in the last verified frame (0..64)
//   coords_valid : xs/ys/city_count hold a verified frame
//   load_done    : one-cycle pulse on a verified frame
//   load_err     : one-cycle pulse on a rejected frame
//   busy         : a frame is in progress (state other than IDLE)
// ---------------------------------------------------------------------------
module tsp_city_loader #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         MAX_CITIES = 64
) (
  input  logic               clk,
  input  logic               rst,
  tsp_city_loader_if.slave   bus,
  output logic [63:0][7:0]   xs,
  output logic [63:0][7:0]   ys,
  output logic [6:0]         city_count,
  output logic               coords_valid,
  output logic               load_done,
  output logic               load_err,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    XB    = 3'd2,
    YB    = 3'd3,
    CSUM  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t     state;
  logic [5:0] idx;       // city currently being filled
  logic [6:0] n_cities;  // N of the frame in progress
  logic [7:0] csum;      // running XOR of N and coordinate bytes

  logic       fire;
  logic [7:0] din;

  assign fire = bus.in_valid && bus.in_ready;
  assign din  = bus.in_data;
  assign busy = (state != IDLE);

  // in_ready is a registered flag, set on each transition to reflect the
  // state being entered, so it never depends combinationally on in_valid.
  always_ff @(posedge clk) begin
    // NOTE: the coordinate arrays are real state visible on the ports and
    // must read zero after reset, so they are reset like any other register
    // rather than left as an unreset memory.
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      n_cities     <= '0;
      csum         <= '0;
      bus.in_ready <= 1'b0;
      xs           <= '0;
      ys           <= '0;
      city_count   <= '0;
      coords_valid <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      // Pulses default low; in_ready defaults high (only FIN drops it).
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      bus.in_ready <= 1'b1;

      case (state)
        IDLE: begin
          // Anything but the header is discarded while hunting for a frame.
          if (fire && din == HEADER) state <= COUNT;
        end

        COUNT: begin
          if (fire) begin
            if (din != 8'd0 && int'(din) <= MAX_CITIES) begin
              n_cities     <= din[6:0];
              idx          <= '0;
              csum         <= din;
              coords_valid <= 1'b0;
              xs           <= '0;
              ys           <= '0;
              state        <= XB;
            end else begin
              // Illegal count: previous frame's arrays stay untouched.
              load_err <= 1'b1;
              state    <= IDLE;
            end
          end
        end

        XB: begin
          if (fire) begin
            xs[idx] <= din;
            csum    <= csum ^ din;
            state   <= YB;
          end
        end

        YB: begin
          if (fire) begin
            ys[idx] <= din;
            csum    <= csum ^ din;
            if ({1'b0, idx} == n_cities - 7'd1) begin
              state <= CSUM;
            end else begin
              idx   <= idx + 6'd1;
              state <= XB;
            end
          end
        end

        CSUM: begin
          if (fire) begin
            if (din == csum) begin
              // load_done is high during the single FIN cycle, one cycle
              // after the checksum byte transfers.
              load_done    <= 1'b1;
              bus.in_ready <= 1'b0;
              state        <= FIN;
            end else begin
              // Bad frame: its partial entries remain, coords_valid stays 0.
              load_err <= 1'b1;
              state    <= IDLE;
            end
          end
        end

        FIN: begin
          coords_valid <= 1'b1;
          city_count   <= n_cities;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsp_city_loader.sv
// ---------------------------------------------------------------------------
// tb_tsp_city_loader
// Self-checking bench: frames are built at the frame level (good, bad
// checksum, bad count), driven byte by byte with random in_valid gaps, and
// the outputs are compared against a frame-level model of the arrays.
// ---------------------------------------------------------------------------
module tb_tsp_city_loader;

  localparam logic [7:0] HDR = 8'hA5;

  typedef enum int { GOOD = 0, BAD_CSUM = 1, BAD_COUNT = 2 } kind_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tsp_city_loader_if bus ();

  logic [63:0][7:0] xs, ys;
  logic [6:0]       city_count;
  logic             coords_valid, load_done, load_err, busy;

  tsp_city_loader #(.HEADER(HDR), .MAX_CITIES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .xs           (xs),
    .ys           (ys),
    .city_count   (city_count),
    .coords_valid (coords_valid),
    .load_done    (load_done),
    .load_err     (load_err),
    .busy         (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitor.
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (load_done) done_cnt++;
      if (load_err)  err_cnt++;
      if (load_done && load_err) both_cnt++;
    end
  end

  // Frame payload and reference model.
  logic [7:0] f_x [64];
  logic [7:0] f_y [64];
  logic [7:0] m_xs [64];
  logic [7:0] m_ys [64];
  int         m_count;
  logic       m_valid;
  int         exp_done, exp_err;
  bit         gaps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_xs[i] = 8'h00;
      m_ys[i] = 8'h00;
    end
    m_count = 0;
    m_valid = 1'b0;
  endtask

  // Called and returns at a negedge; on return the byte has transferred on
  // the preceding posedge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (gaps && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_junk(input int cnt);
    logic [7:0] b;
    for (int i = 0; i < cnt; i++) begin
      do b = 8'($urandom); while (b == HDR);
      send_byte(b);
    end
  endtask

  // Sends one frame of n cities from f_x/f_y, checks the immediate pulse
  // and updates the model from the frame's outcome.
  task automatic send_frame(input int n, input logic [7:0] nbyte, input kind_t kind);
    logic [7:0] c;
    send_byte(HDR);
    send_byte(nbyte);
    if (kind == BAD_COUNT) begin
      check("err_after_count", load_err, 1);
      check("no_done_count", load_done, 0);
      exp_err++;
      return;
    end
    c = nbyte;
    for (int i = 0; i < n; i++) begin
      send_byte(f_x[i]);
      send_byte(f_y[i]);
      c = c ^ f_x[i] ^ f_y[i];
    end
    if (kind == BAD_CSUM) c = c ^ (8'h01 << $urandom_range(0, 7));
    send_byte(c);
    for (int i = 0; i < 64; i++) begin
      m_xs[i] = (i < n) ? f_x[i] : 8'h00;
      m_ys[i] = (i < n) ? f_y[i] : 8'h00;
    end
    if (kind == GOOD) begin
      check("done_latency", load_done, 1);
      check("no_err_good", load_err, 0);
      check("ready_low_fin", bus.in_ready, 0);
      exp_done++;
      m_count = n;
      m_valid = 1'b1;
    end else begin
      check("err_after_csum", load_err, 1);
      check("no_done_bad", load_done, 0);
      exp_err++;
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s_xs%0d", tag, i), xs[i], m_xs[i]);
      check($sformatf("%s_ys%0d", tag, i), ys[i], m_ys[i]);
    end
    check({tag, "_count"}, city_count, m_count);
    check({tag, "_valid"}, coords_valid, m_valid);
    check({tag, "_done_cnt"}, done_cnt, exp_done);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_both"}, both_cnt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic random_coords(input int n);
    for (int i = 0; i < n; i++) begin
      f_x[i] = 8'($urandom);
      f_y[i] = 8'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    kind_t k;
    logic [7:0] nb;

    exp_done = 0;
    exp_err  = 0;
    gaps     = 1'b0;
    model_reset();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", coords_valid, 0);
    check("rst_count", city_count, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bus.in_ready, 1);

    // Two-city frame (checksum 8'h42), then the same with a wrong checksum.
    f_x[0] = 8'h10; f_y[0] = 8'h20; f_x[1] = 8'h30; f_y[1] = 8'h40;
    send_frame(2, 8'd2, GOOD);
    compare_all("two_good");
    send_frame(2, 8'd2, BAD_CSUM);
    compare_all("two_badcsum");

    // Reload a good frame, then illegal counts 0 and 65 must leave it intact.
    random_coords(5);
    send_frame(5, 8'd5, GOOD);
    compare_all("five_good");
    send_frame(0, 8'h00, BAD_COUNT);
    compare_all("count_zero");
    send_frame(0, 8'h41, BAD_COUNT);
    compare_all("count_65");

    // Leading junk before the header is ignored.
    send_byte(8'h00);
    send_byte(8'hFF);
    f_x[0] = 8'h05; f_y[0] = 8'h06;
    send_frame(1, 8'd1, GOOD);
    compare_all("junk_lead");

    // Full 64-city frame with header bytes embedded as data and random gaps.
    gaps = 1'b1;
    random_coords(64);
    f_x[7] = HDR; f_y[20] = HDR;
    send_frame(64, 8'd64, GOOD);
    compare_all("full64");

    // Reset in the middle of a frame: no error pulse, everything cleared.
    gaps = 1'b0;
    random_coords(5);
    send_byte(HDR);
    send_byte(8'd5);
    for (int i = 0; i < 3; i++) begin
      send_byte(f_x[i]);
      send_byte(f_y[i]);
    end
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", bus.in_ready, 0);
    rst = 1'b1;
    model_reset();
    compare_all("midrst");
    random_coords(4);
    send_frame(4, 8'd4, GOOD);
    compare_all("after_rst");

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      gaps = ($urandom_range(0, 1) == 1);
      send_junk($urandom_range(0, 2));
      n = ($urandom_range(0, 7) == 0) ? 64 : $urandom_range(1, 12);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: k = GOOD;
        6, 7:             k = BAD_CSUM;
        default:          k = BAD_COUNT;
      endcase
      if (k == BAD_COUNT) begin
        nb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255));
      end else begin
        nb = 8'(n);
      end
      random_coords(n);
      send_frame(n, nb, k);
      compare_all($sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
